quad_core_dispatch: RTL and testbench
=====================================

Name: quad_core_dispatch

Overview:
- Issue-side controller for the four-lane quad_core FPU array; it is the initiator and collector for the core's `en` / `fi` interface.
- Accepts operand jobs (a,b,c,d) one at a time over a valid/ready stream and packs up to four jobs into a batch (lanes 0-3).
- Launches each batch with a single `en` pulse, waits for each active lane's `fi`, then captures that lane's `g`.
- Returns the results in lane order over a valid/ready result stream.

Parameters:
- MIN_LAT, 1: first WAIT-cycle timer value at which `fi` is trusted; masks stale `fi` from the previous batch.
- TIMEOUT, 64: WAIT-cycle limit before the batch is abandoned; must be > MIN_LAT.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- job_valid  input  1  upstream job offered
- job_ready  output  1  dispatcher accepts a job this cycle
- job_a, job_b, job_c, job_d  input  32 each  job operands
- job_last  input  1  close the batch after this job (partial batch)
- res_valid  output  1  result available
- res_ready  input  1  downstream accepts result
- res_data  output  32  captured g of lane res_lane
- res_lane  output  2  lane index of res_data
- res_last  output  1  final result of the batch
- busy  output  1  batch in progress
- err_timeout  output  1  sticky timeout flag
- en  output  1  one-cycle launch pulse to all four lanes
- a0,b0,c0,d0 / a1,b1,c1,d1 / a2,b2,c2,d2 / a3,b3,c3,d3  output  32 each  lane operands
- g0..g3  input  32 each  lane results
- fi0..fi3  input  1 each  lane finish flags, sampled as levels

Behaviour:
- States: FILL, LAUNCH, WAIT, DRAIN.
- Reset (synchronous, any state) clears everything on that clock edge:
  - state to FILL; fill count to 0; active-lane mask to 0; done mask to 0; timer to 0; result index to 0;
  - all operand registers, result buffers and err_timeout to 0.
- Output values while in reset: en=0, res_valid=0, res_last=0, res_data=0, res_lane=0, busy=0, err_timeout=0, all a..d=0, job_ready=0.
- FILL:
  - job_ready=1.
  - On accept (job_valid & job_ready): write job_a..d into the lane[cnt] operand registers, set active[cnt], increment cnt.
  - If cnt was 3, or job_last=1, go to LAUNCH next cycle. Unfilled lanes keep zero operands and stay inactive.
  - job_last on the 4th job behaves exactly like a full batch.
- LAUNCH: en=1 for exactly this cycle; job_ready=0; timer cleared; done cleared; next state WAIT.
- WAIT:
  - timer increments every cycle, starting at 0 in the first WAIT cycle.
  - Sampling: for each lane k with active[k]=1, done[k]=0, timer>=MIN_LAT and fi_k=1, latch g_k into rbuf[k] and set done[k].
  - Inactive lanes are ignored.
  - Exit to DRAIN: the cycle after done covers active, counting captures made in the current cycle.
  - Timeout: if timer==TIMEOUT-1 and not all active lanes are done, set err_timeout, discard the batch, clear operands/active/cnt, and go to FILL.
  - Timeout has priority only if the final capture does not occur in that same cycle.
- DRAIN:
  - res_valid=1; res_data=rbuf[idx]; res_lane=idx; res_last=(idx == highest active lane).
  - Hold all three stable while res_ready=0.
  - On handshake, idx increments.
  - Handshake with res_last=1: idx to 0; clear operands, active and cnt; go to FILL.
- Operand outputs are registered and stay constant from LAUNCH through the end of WAIT/DRAIN.
- busy = (state != FILL) | (cnt != 0).
- err_timeout is sticky; only rst clears it.
- job_valid is ignored outside FILL. No job is accepted in the cycle DRAIN completes; FILL begins the next cycle.

Test Plan:
- Bench fppu model: g_k = a_k ^ b_k, fi_k high from 3 cycles after en.
- Full batch:
  - Stimulus: four jobs with a=0x3F800000, b=0x00000001, 0x2, 0x4, 0x8; res_ready=1.
  - Response: en high for exactly 1 cycle, the cycle after the 4th accept.
  - Results 0x3F800001, 0x3F800002, 0x3F800004, 0x3F800008 appear with res_lane 0..3; res_last only on lane 3.
- Partial batch:
  - Stimulus: two jobs, the second with job_last=1.
  - Response: en pulses; lanes 2/3 have zero operands; exactly two results, with res_last on lane 1.
- Backpressure:
  - Stimulus: hold res_ready=0 for 5 cycles in DRAIN.
  - Response: res_data/res_lane stable; no new job_ready until the last result is taken.
- Stale fi / staggered finish:
  - Stimulus: MIN_LAT=2 with fi0 held high from the prior batch; lanes finish in order 3,1,0,2.
  - Response: lane 0 is not captured before timer=2; output order is still 0,1,2,3 with the correct g values.
- Timeout:
  - Stimulus: fi2 never asserts; TIMEOUT=8.
  - Response: err_timeout=1 after 8 WAIT cycles, no res_valid, back to FILL (job_ready=1, busy=0); the next batch completes normally with err_timeout still 1.
- Reset mid-WAIT:
  - Stimulus: assert rst for 1 cycle.
  - Response: en=0, res_valid=0, busy=0, err_timeout=0 next cycle; job_ready=1 after rst drops.

Source files
------------

// File: rtl/quad_core_dispatch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// quad_core_dispatch : batches operand jobs onto the four quad_core FPU lanes
// and returns the lane results in order.                       Revision 1.0
// ---------------------------------------------------------------------------
module quad_core_dispatch #(
  parameter int MIN_LAT = 1,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_a,
  input  logic [31:0] job_b,
  input  logic [31:0] job_c,
  input  logic [31:0] job_d,
  input  logic        job_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_lane,
  output logic        res_last,
  output logic        busy,
  output logic        err_timeout,
  output logic        en,
  output logic [31:0] a0, b0, c0, d0,
  output logic [31:0] a1, b1, c1, d1,
  output logic [31:0] a2, b2, c2, d2,
  output logic [31:0] a3, b3, c3, d3,
  input  logic [31:0] g0, g1, g2, g3,
  input  logic        fi0, fi1, fi2, fi3
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT, S_DRAIN} state_t;

  state_t          state, state_nx;
  logic [2:0]      cnt;
  logic [3:0]      active, done;
  logic [TW-1:0]   timer;
  logic [1:0]      idx;
  logic            err_q;
  logic [31:0]     op_a [4];
  logic [31:0]     op_b [4];
  logic [31:0]     op_c [4];
  logic [31:0]     op_d [4];
  logic [31:0]     rbuf [4];
  logic [31:0]     g_in [4];
  logic [3:0]      fi_in;
  logic [1:0]      last_lane;

  logic            accept, timeout_hit, drain_hs, drain_end;
  logic            en_c, job_ready_c, res_valid_c, res_last_c;
  logic [3:0]      cap;

  assign g_in[0]   = g0;
  assign g_in[1]   = g1;
  assign g_in[2]   = g2;
  assign g_in[3]   = g3;
  assign fi_in     = {fi3, fi2, fi1, fi0};
  // Lanes fill contiguously, so the highest active lane is cnt-1 (cnt=4 wraps to 3).
  assign last_lane = cnt[1:0] - 2'd1;
  assign res_last_c = (idx == last_lane);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    drain_hs    = 1'b0;
    drain_end   = 1'b0;
    en_c        = 1'b0;
    job_ready_c = 1'b0;
    res_valid_c = 1'b0;
    cap         = '0;
    case (state)
      S_FILL: begin
        job_ready_c = 1'b1;
        accept      = job_valid;
        if (accept && (cnt == 3'd3 || job_last)) state_nx = S_LAUNCH;
      end
      S_LAUNCH: begin
        en_c     = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        cap = active & ~done & fi_in & {4{timer >= TW'(MIN_LAT)}};
        // A final capture in the last allowed cycle still wins over the timeout.
        if (((done | cap) & active) == active) begin
          state_nx = S_DRAIN;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nx    = S_FILL;
        end
      end
      S_DRAIN: begin
        res_valid_c = 1'b1;
        drain_hs    = res_ready;
        if (res_ready && res_last_c) begin
          drain_end = 1'b1;
          state_nx  = S_FILL;
        end
      end
      default: state_nx = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= '0;
      done   <= '0;
      timer  <= '0;
      idx    <= '0;
      err_q  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
        op_c[k] <= '0;
        op_d[k] <= '0;
        rbuf[k] <= '0;
      end
    end else begin
      case (state)
        S_FILL: begin
          if (accept) begin
            op_a[cnt[1:0]]   <= job_a;
            op_b[cnt[1:0]]   <= job_b;
            op_c[cnt[1:0]]   <= job_c;
            op_d[cnt[1:0]]   <= job_d;
            active[cnt[1:0]] <= 1'b1;
            cnt              <= cnt + 3'd1;
          end
        end
        S_LAUNCH: begin
          timer <= '0;
          done  <= '0;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          done  <= done | cap;
          for (int k = 0; k < 4; k++) begin
            if (cap[k]) rbuf[k] <= g_in[k];
          end
          if (timeout_hit) begin
            err_q  <= 1'b1;
            cnt    <= '0;
            active <= '0;
            for (int k = 0; k < 4; k++) begin
              op_a[k] <= '0;
              op_b[k] <= '0;
              op_c[k] <= '0;
              op_d[k] <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (drain_end) begin
            idx    <= '0;
            cnt    <= '0;
            active <= '0;
            for (int k = 0; k < 4; k++) begin
              op_a[k] <= '0;
              op_b[k] <= '0;
              op_c[k] <= '0;
              op_d[k] <= '0;
            end
          end else if (drain_hs) begin
            idx <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Every output reads zero while reset is held, whatever state is being left.
  assign job_ready   = job_ready_c & ~rst;
  assign en          = en_c & ~rst;
  assign res_valid   = res_valid_c & ~rst;
  assign res_last    = res_valid_c & res_last_c & ~rst;
  assign res_data    = rst ? '0 : rbuf[idx];
  assign res_lane    = rst ? '0 : idx;
  assign busy        = ~rst & ((state != S_FILL) | (cnt != 3'd0));
  assign err_timeout = err_q & ~rst;

  assign a0 = rst ? '0 : op_a[0];
  assign b0 = rst ? '0 : op_b[0];
  assign c0 = rst ? '0 : op_c[0];
  assign d0 = rst ? '0 : op_d[0];
  assign a1 = rst ? '0 : op_a[1];
  assign b1 = rst ? '0 : op_b[1];
  assign c1 = rst ? '0 : op_c[1];
  assign d1 = rst ? '0 : op_d[1];
  assign a2 = rst ? '0 : op_a[2];
  assign b2 = rst ? '0 : op_b[2];
  assign c2 = rst ? '0 : op_c[2];
  assign d2 = rst ? '0 : op_d[2];
  assign a3 = rst ? '0 : op_a[3];
  assign b3 = rst ? '0 : op_b[3];
  assign c3 = rst ? '0 : op_c[3];
  assign d3 = rst ? '0 : op_d[3];

endmodule
`default_nettype wire

// File: tb/tb_quad_core_dispatch.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_quad_core_dispatch : scoreboard bench with a behavioural four-lane FPU.
// ---------------------------------------------------------------------------
module tb_quad_core_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0, job_last = 1'b0, res_ready = 1'b0;
  logic [31:0] job_a = '0, job_b = '0, job_c = '0, job_d = '0;
  logic        job_ready, res_valid, res_last, busy, err_timeout, en;
  logic [31:0] res_data;
  logic [1:0]  res_lane;
  logic [31:0] oa [4];
  logic [31:0] ob [4];
  logic [31:0] oc [4];
  logic [31:0] od [4];
  logic [31:0] gm [4];
  logic        fim [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  quad_core_dispatch #(.MIN_LAT(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a(job_a), .job_b(job_b), .job_c(job_c), .job_d(job_d), .job_last(job_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_lane(res_lane), .res_last(res_last),
    .busy(busy), .err_timeout(err_timeout), .en(en),
    .a0(oa[0]), .b0(ob[0]), .c0(oc[0]), .d0(od[0]),
    .a1(oa[1]), .b1(ob[1]), .c1(oc[1]), .d1(od[1]),
    .a2(oa[2]), .b2(ob[2]), .c2(oc[2]), .d2(od[2]),
    .a3(oa[3]), .b3(ob[3]), .c3(oc[3]), .d3(od[3]),
    .g0(gm[0]), .g1(gm[1]), .g2(gm[2]), .g3(gm[3]),
    .fi0(fim[0]), .fi1(fim[1]), .fi2(fim[2]), .fi3(fim[3])
  );

  // Lane model: g = a ^ b once finished (garbage before), fi stays high until next en.
  int         lat   [4] = '{3, 3, 3, 3};
  bit         never [4] = '{0, 0, 0, 0};
  bit         hold0 = 1'b0;
  logic [7:0] since;

  always @(posedge clk) begin
    if (rst)                               since <= 8'd0;
    else if (en)                           since <= 8'd1;
    else if (since != 0 && since != 8'hFF) since <= since + 8'd1;
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      gm[k]  = (since >= 8'(lat[k])) ? (oa[k] ^ ob[k]) : 32'hDEADBEEF;
      fim[k] = !never[k] && ((since >= 8'(lat[k])) ||
               (k == 0 && hold0 && since >= 8'd1 && since <= 8'd2));
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  lane;
    logic        last;
  } exp_t;

  exp_t sbq [$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got lane=%0d data=%h, none expected", res_lane, res_data);
      end else begin
        mon_e = sbq.pop_front();
        if (res_data !== mon_e.data || res_lane !== mon_e.lane || res_last !== mon_e.last) begin
          errors++;
          $display("FAIL result: got lane=%0d data=%h last=%b, expected lane=%0d data=%h last=%b",
                   res_lane, res_data, res_last, mon_e.lane, mon_e.data, mon_e.last);
        end
      end
    end
  end

  logic [31:0] ja [4];
  logic [31:0] jb [4];
  logic [31:0] jc [4];
  logic [31:0] jd [4];

  // Offers n jobs from ja..jd (job_last on the n-th) and, if push, queues expected results.
  task automatic send_batch(input int n, input bit push);
    exp_t tmp;
    bit   got;
    for (int i = 0; i < n; i++) begin
      job_valid = 1'b1;
      job_a = ja[i]; job_b = jb[i]; job_c = jc[i]; job_d = jd[i];
      job_last = (i == n - 1);
      got = 1'b0;
      for (int w = 0; w < 100 && !got; w++) begin
        @(negedge clk);
        if (job_ready) got = 1'b1;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL job_accept: job %0d never accepted", i);
      end
      if (push) begin
        tmp.data = ja[i] ^ jb[i];
        tmp.lane = 2'(i);
        tmp.last = (i == n - 1);
        sbq.push_back(tmp);
      end
      @(posedge clk); #1;
    end
    job_valid = 1'b0;
    job_last  = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int w = 0; w < 200 && !idle; w++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0) idle = 1'b1;
    end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL idle: busy=%b pending=%0d, expected busy=0 pending=0", busy, sbq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({en, res_valid, res_last, busy, err_timeout, job_ready} !== 6'b0 ||
        res_data !== 32'h0 || res_lane !== 2'd0 || oa[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b rv=%b busy=%b err=%b jr=%b data=%h, expected all 0",
               en, res_valid, busy, err_timeout, job_ready, res_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: jr=%b busy=%b rv=%b, expected jr=1 busy=0 rv=0",
               job_ready, busy, res_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_batch();
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ja[i] = 32'h3F800000; jb[i] = 32'h1 << i;
      jc[i] = 32'h100 + i;  jd[i] = 32'hC0DE0000 + i;
    end
    send_batch(4, 1'b1);
    @(negedge clk);
    checks++;
    if (en !== 1'b1) begin
      errors++; $display("FAIL full_en_pulse: en=%b, expected 1", en);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oa[k] !== ja[k] || ob[k] !== jb[k] || oc[k] !== jc[k] || od[k] !== jd[k]) begin
        errors++;
        $display("FAIL full_operands lane %0d: got %h %h %h %h, expected %h %h %h %h",
                 k, oa[k], ob[k], oc[k], od[k], ja[k], jb[k], jc[k], jd[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (en !== 1'b0) begin
      errors++; $display("FAIL full_en_width: en=%b, expected 0", en);
    end
    wait_idle();
  endtask

  task automatic test_partial();
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ja[i] = 32'h11111111 * (i + 1); jb[i] = 32'h0F0F0000 + i;
      jc[i] = 32'hAAAA0000 + i;       jd[i] = 32'h5555_0000 + i;
    end
    send_batch(2, 1'b1);
    @(negedge clk);
    checks++;
    if (en !== 1'b1) begin
      errors++; $display("FAIL partial_en: en=%b, expected 1", en);
    end
    checks++;
    if ((oa[2] | ob[2] | oc[2] | od[2] | oa[3] | ob[3] | oc[3] | od[3]) !== 32'h0) begin
      errors++;
      $display("FAIL partial_zero_lanes: a2=%h b2=%h a3=%h b3=%h, expected 0", oa[2], ob[2], oa[3], ob[3]);
    end
    checks++;
    if (oa[1] !== ja[1] || od[1] !== jd[1]) begin
      errors++; $display("FAIL partial_lane1: a1=%h d1=%h, expected %h %h", oa[1], od[1], ja[1], jd[1]);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] hd;
    logic [1:0]  hl;
    bit          seen = 1'b0;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ja[i] = $urandom; jb[i] = $urandom; jc[i] = $urandom; jd[i] = $urandom;
    end
    send_batch(4, 1'b1);
    for (int w = 0; w < 50 && !seen; w++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL bp_valid: res_valid never rose, expected 1");
    end
    hd = res_data; hl = res_lane;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== hd || res_lane !== hl) begin
        errors++;
        $display("FAIL bp_hold: rv=%b data=%h lane=%0d, expected 1 %h %0d", res_valid, res_data, res_lane, hd, hl);
      end
      checks++;
      if (job_ready !== 1'b0) begin
        errors++; $display("FAIL bp_job_ready: jr=%b, expected 0", job_ready);
      end
    end
    @(posedge clk); #1 res_ready = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (res_valid) begin
        checks++;
        if (job_ready !== 1'b0) begin
          errors++; $display("FAIL bp_drain_ready: jr=%b, expected 0", job_ready);
        end
        if (res_last) seen = 1'b1;
      end
    end
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_refill: jr=%b busy=%b, expected 1 0", job_ready, busy);
    end
    wait_idle();
  endtask

  task automatic test_stale_fi();
    res_ready = 1'b1;
    lat   = '{5, 4, 6, 3};
    hold0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ja[i] = $urandom; jb[i] = $urandom; jc[i] = 32'h0; jd[i] = 32'h0;
    end
    send_batch(4, 1'b1);
    wait_idle();
    hold0 = 1'b0;
    lat   = '{3, 3, 3, 3};
  endtask

  task automatic test_timeout();
    int n = 0;
    bit rv_seen = 1'b0;
    bit hit = 1'b0;
    res_ready = 1'b1;
    never[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ja[i] = 32'hA0000000 + i; jb[i] = 32'h5; jc[i] = 32'h0; jd[i] = 32'h0;
    end
    send_batch(4, 1'b0);
    @(negedge clk);
    checks++;
    if (en !== 1'b1) begin
      errors++; $display("FAIL to_en: en=%b, expected 1", en);
    end
    for (int w = 0; w < 20 && !hit; w++) begin
      @(negedge clk);
      n++;
      if (res_valid) rv_seen = 1'b1;
      if (err_timeout) hit = 1'b1;
    end
    checks++;
    if (n !== 9 || !hit) begin
      errors++; $display("FAIL to_latency: err rose %0d cycles after en (hit=%b), expected 9", n, hit);
    end
    checks++;
    if (rv_seen) begin
      errors++; $display("FAIL to_no_result: res_valid seen=1, expected 0");
    end
    checks++;
    if (job_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL to_fill: jr=%b busy=%b, expected 1 0", job_ready, busy);
    end
    never[2] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      ja[i] = 32'h12345678 + i; jb[i] = 32'h00FF00FF << i;
    end
    send_batch(4, 1'b1);
    wait_idle();
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++; $display("FAIL to_sticky: err=%b, expected 1", err_timeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    res_ready = 1'b1;
    send_batch(4, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({en, res_valid, busy, err_timeout, job_ready} !== 5'b0 || oa[0] !== 32'h0) begin
      errors++;
      $display("FAIL rst_during: en=%b rv=%b busy=%b err=%b jr=%b a0=%h, expected all 0",
               en, res_valid, busy, err_timeout, job_ready, oa[0]);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({en, res_valid, busy, err_timeout} !== 4'b0 || job_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: en=%b rv=%b busy=%b err=%b jr=%b, expected 0 0 0 0 1",
               en, res_valid, busy, err_timeout, job_ready);
    end
    @(posedge clk); #1;
    ja[0] = 32'hCAFEF00D; jb[0] = 32'h0000FFFF;
    send_batch(1, 1'b1);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_full_batch();
    test_partial();
    test_backpressure();
    test_stale_fi();
    test_timeout();
    test_reset_mid_wait();
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL leftover: %0d results never produced, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
